// File: rtl/key_schedule_ctrl.sv
// AES-128 key-schedule controller: loads a cipher key and streams round keys 0..ROUNDS over valid/ready.
// Optional round-key store for reverse-order (decrypt) use is enabled by KEY_SCHEDULE_STORE_EN.

// Combinational KeyExpansion stage: one AES-128 round of the key schedule.
module key_expansion (
  input  logic [127:0] round_Key,
  input  logic [3:0]   round_Number,
  output logic [127:0] next_Key
);
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (a^254, maps 0 to 0) followed by the AES affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] s;
    logic [7:0] p;
    s = a;
    p = 8'h01;
    for (int i = 0; i < 7; i++) begin
      s = gf_mul(s, s);
      p = gf_mul(p, s);
    end
    return p ^ {p[6:0], p[7]} ^ {p[5:0], p[7:6]} ^ {p[4:0], p[7:5]} ^ {p[3:0], p[7:4]} ^ 8'h63;
  endfunction

  logic [7:0]  rcon;
  logic [31:0] w0, w1, w2, w3, rot, temp, n0, n1, n2, n3;

  always_comb begin
    case (round_Number)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign {w0, w1, w2, w3} = round_Key;
  assign rot  = {w3[23:0], w3[31:24]};
  assign temp = {sbox(rot[31:24]) ^ rcon, sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
  assign n0 = w0 ^ temp;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
  assign next_Key = {n0, n1, n2, n3};
endmodule

module key_schedule_ctrl #(
  parameter int LENGTH = 128,
  parameter int ROUNDS = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LENGTH-1:0] cipher_Key,
  input  logic              key_Ready,
  output logic              key_Valid,
  output logic [LENGTH-1:0] round_Key_Out,
  output logic [3:0]        round_Index,
  output logic              busy,
  output logic              done,
  output logic [1:0]        state_o
`ifdef KEY_SCHEDULE_STORE_EN
  ,
  input  logic [3:0]        rd_Index,
  output logic [LENGTH-1:0] rd_Key
`endif
);
  // Handshake: a key transfers on a rising edge where key_Valid && key_Ready;
  // while key_Valid is high and key_Ready is low every output holds stable.
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  localparam logic [3:0] LAST = 4'(ROUNDS);

  state_t            state_q, state_d;
  logic [LENGTH-1:0] key_q, key_d, next_key;
  logic [3:0]        cnt_q, cnt_d, rnd_num;
  logic              hs;

  // Clamp keeps the expansion's round number within 1..ROUNDS even when idle on the last key.
  assign rnd_num = (cnt_q == LAST) ? LAST : cnt_q + 4'd1;
  assign hs      = (state_q == RUN) && key_Ready;

  key_expansion u_key_expansion (
    .round_Key    (key_q),
    .round_Number (rnd_num),
    .next_Key     (next_key)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          key_d   = cipher_Key;
          cnt_d   = 4'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (hs) begin
          if (cnt_q == LAST) begin
            state_d = DONE;
          end else begin
            key_d = next_key;
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign key_Valid     = (state_q == RUN);
  assign round_Key_Out = key_q;
  assign round_Index   = cnt_q;
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign state_o       = state_q;

`ifdef KEY_SCHEDULE_STORE_EN
  logic [LENGTH-1:0] store_q [0:ROUNDS];
  logic [LENGTH-1:0] rd_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= ROUNDS; i++) store_q[i] <= '0;
      rd_q <= '0;
    end else begin
      if (hs) store_q[cnt_q] <= key_q;
      rd_q <= (rd_Index <= LAST) ? store_q[rd_Index] : '0;
    end
  end

  assign rd_Key = rd_q;
`endif
endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Directed self-checking bench for key_schedule_ctrl; exercises the round-key store when
// KEY_SCHEDULE_STORE_EN is defined.
module tb_key_schedule_ctrl;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [127:0] cipher_Key = '0;
  logic         key_Ready = 1'b0;
  logic         key_Valid;
  logic [127:0] round_Key_Out;
  logic [3:0]   round_Index;
  logic         busy;
  logic         done;
  logic [1:0]   state_o;
`ifdef KEY_SCHEDULE_STORE_EN
  logic [3:0]   rd_Index = 4'd0;
  logic [127:0] rd_Key;
`endif

  int total = 0;
  int bad = 0;
  logic [127:0] exp_q [$];
  logic [127:0] got_keys [0:15];
  logic [127:0] fips [0:10];

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  key_schedule_ctrl #(.LENGTH(128), .ROUNDS(10)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .cipher_Key    (cipher_Key),
    .key_Ready     (key_Ready),
    .key_Valid     (key_Valid),
    .round_Key_Out (round_Key_Out),
    .round_Index   (round_Index),
    .busy          (busy),
    .done          (done),
    .state_o       (state_o)
`ifdef KEY_SCHEDULE_STORE_EN
    ,
    .rd_Index      (rd_Index),
    .rd_Key        (rd_Key)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // mode 0: ready held high; mode 1: ready follows the 1,0,0,1 pattern.
  // busy_start_at: cycle on which a second start (key 0) is pulsed while busy (0 = none).
  // reset_at_idx: reset as soon as this index is presented (-1 = none).
  task automatic run_sched(input logic [127:0] key, input int mode, input int busy_start_at,
                           input int reset_at_idx, output int hs, output int done_at,
                           output int done_cnt);
    logic [3:0]   pat;
    logic [127:0] prev_key;
    logic [3:0]   prev_idx;
    logic         stalled;
    pat      = 4'b1001;
    hs       = 0;
    done_at  = -1;
    done_cnt = 0;
    stalled  = 1'b0;
    prev_key = '0;
    prev_idx = '0;
    for (int i = 0; i < 16; i++) got_keys[i] = '0;
    @(negedge clk);
    cipher_Key = key;
    start      = 1'b1;
    key_Ready  = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n < 200; n++) begin
      if (n == 1) begin
        chk("first_valid", 128'(key_Valid), 128'(1'b1));
        chk("first_index", 128'(round_Index), 128'd0);
      end
      if (stalled) begin
        chk("stall_valid", 128'(key_Valid), 128'(1'b1));
        chk("stall_key", round_Key_Out, prev_key);
        chk("stall_index", 128'(round_Index), 128'(prev_idx));
      end
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = n;
      end
      if (done_at >= 0 && n >= done_at + 3) break;
      if (reset_at_idx >= 0 && key_Valid && round_Index == 4'(reset_at_idx)) begin
        rst       = 1'b1;
        key_Ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_valid", 128'(key_Valid), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_index", 128'(round_Index), 128'd0);
        chk("rst_key", round_Key_Out, 128'd0);
        return;
      end
      start      = (n == busy_start_at);
      cipher_Key = start ? 128'd0 : key;
      key_Ready  = (mode == 0) ? 1'b1 : pat[n % 4];
      if (key_Valid && key_Ready) begin
        chk("hs_index", 128'(round_Index), 128'(hs));
        if (hs < 16) got_keys[hs] = round_Key_Out;
        hs++;
      end
      stalled  = key_Valid && !key_Ready;
      prev_key = round_Key_Out;
      prev_idx = round_Index;
      @(negedge clk);
    end
    start     = 1'b0;
    key_Ready = 1'b0;
    chk("done_seen", 128'(done_at >= 0), 128'd1);
    chk("done_pulses", 128'(done_cnt), 128'd1);
    chk("idle_after", 128'({busy, key_Valid}), 128'd0);
  endtask

  task automatic check_fips_keys(input string tag);
    exp_q.delete();
    for (int i = 0; i <= 10; i++) exp_q.push_back(fips[i]);
    for (int i = 0; i <= 10; i++) chk(tag, got_keys[i], exp_q.pop_front());
  endtask

  initial begin
    int hs, done_at, done_cnt;
    fips[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    // Reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_valid", 128'(key_Valid), 128'd0);
    chk("reset_key", round_Key_Out, 128'd0);
    chk("reset_index", 128'(round_Index), 128'd0);
    chk("reset_busy_done", 128'({busy, done}), 128'd0);
    chk("reset_state", 128'(state_o), 128'd0);

    // FIPS-197 key with ready high: done lands on cycle 12
    run_sched(FIPS_KEY, 0, 0, -1, hs, done_at, done_cnt);
    chk("fips_hs", 128'(hs), 128'd11);
    chk("fips_done_cycle", 128'(done_at), 128'd12);
    check_fips_keys("fips_key");
    chk("fips_hold_last", round_Key_Out, fips[10]);

`ifdef KEY_SCHEDULE_STORE_EN
    @(negedge clk);
    rd_Index = 4'd10;
    @(negedge clk);
    chk("rd_10", rd_Key, fips[10]);
    rd_Index = 4'd0;
    @(negedge clk);
    chk("rd_0", rd_Key, fips[0]);
    rd_Index = 4'd12;
    @(negedge clk);
    chk("rd_12", rd_Key, 128'd0);
    rd_Index = 4'd5;
    @(negedge clk);
    chk("rd_5", rd_Key, fips[5]);
`endif

    // Backpressure
    run_sched(FIPS_KEY, 1, 0, -1, hs, done_at, done_cnt);
    chk("bp_hs", 128'(hs), 128'd11);
    check_fips_keys("bp_key");

    // Start while busy is ignored
    run_sched(FIPS_KEY, 0, 4, -1, hs, done_at, done_cnt);
    chk("busy_start_hs", 128'(hs), 128'd11);
    chk("busy_start_last", got_keys[10], fips[10]);
    chk("busy_start_done_cycle", 128'(done_at), 128'd12);

    // Reset while index 5 is presented, then a full schedule
    run_sched(FIPS_KEY, 0, 0, 5, hs, done_at, done_cnt);
    chk("rst_mid_hs", 128'(hs), 128'd5);
    run_sched(FIPS_KEY, 0, 0, -1, hs, done_at, done_cnt);
    chk("after_rst_hs", 128'(hs), 128'd11);
    check_fips_keys("after_rst_key");

    // All-zero key
    run_sched(128'd0, 0, 0, -1, hs, done_at, done_cnt);
    chk("zero_k0", got_keys[0], 128'd0);
    chk("zero_k1", got_keys[1], 128'h62636363626363636263636362636363);
    chk("zero_k10", got_keys[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
